// File: rtl/bcd_countdown_timer.sv
// Packed-BCD down-counter with load, start, pause and a one-cycle done pulse.
// Decrements once every TICK_DIV running cycles until the count reaches zero.
module bcd_countdown_timer #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   out,
  output logic                  running,
  output logic                  done
);

  localparam int unsigned W        = 4 * DIGITS;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t          r_state,   w_state_nxt;
  logic [PW-1:0]   r_presc,   w_presc_nxt;
  logic [W-1:0]    r_out,     w_out_nxt;
  logic            r_running, w_running_nxt;
  logic            r_done,    w_done_nxt;
  logic [W-1:0]    w_clamped;
  logic [W-1:0]    w_dec;

  always_comb begin
    w_clamped = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  // Borrow ripples through every digit in one pass; zero digits become 9.
  always_comb begin
    logic w_borrow;
    w_dec    = r_out;
    w_borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_borrow) begin
        if (r_out[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_out[4*i +: 4] - 4'd1;
          w_borrow        = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_out_nxt     = r_out;
    w_running_nxt = r_running;
    w_done_nxt    = 1'b0;
    if (load) begin
      w_out_nxt     = w_clamped;
      w_state_nxt   = ST_IDLE;
      w_presc_nxt   = '0;
      w_running_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_presc_nxt = '0;
            if (r_out != '0) begin
              w_state_nxt   = ST_RUN;
              w_running_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!pause) begin
            if (r_presc == PRE_LAST) begin
              w_presc_nxt = '0;
              if (r_out == W'(1)) begin
                w_out_nxt     = '0;
                w_state_nxt   = ST_DONE;
                w_running_nxt = 1'b0;
                w_done_nxt    = 1'b1;
              end else begin
                w_out_nxt = w_dec;
              end
            end else begin
              w_presc_nxt = r_presc + PW'(1);
            end
          end
        end
        ST_DONE: begin
          w_running_nxt = 1'b0;
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_running_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_out     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_out     <= w_out_nxt;
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign out     = r_out;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: two instances (TICK_DIV=4 and 1) share stimulus
// and are compared every cycle against a decimal-arithmetic model, plus literal checks.
module tb_bcd_countdown_timer;

  localparam int DIG = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [7:0]    load_val = '0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [7:0]    out4, out1;
  logic          run4, run1, done4, done1;

  int checks = 0;
  int errors = 0;

  // Model: count value as a plain integer, phase 0=idle 1=counting 2=finished,
  // elapsed counts running cycles since the last decrement.
  int m_val[2]     = '{0, 0};
  int m_phase[2]   = '{0, 0};
  int m_elapsed[2] = '{0, 0};
  bit m_done[2]    = '{0, 0};

  bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .out(out4), .running(run4), .done(done4)
  );

  bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .out(out1), .running(run1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [7:0] lv);
    int v, scale, nib;
    v = 0;
    scale = 1;
    for (int i = 0; i < DIG; i++) begin
      nib = int'((lv >> (4 * i)) & 8'h0f);
      if (nib > 9) nib = 9;
      v += nib * scale;
      scale *= 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_phase[k] = 0; m_elapsed[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int td;
    td = (k == 0) ? 4 : 1;
    m_done[k] = 0;
    if (load) begin
      m_val[k] = clamp_val(load_val);
      m_phase[k] = 0;
      m_elapsed[k] = 0;
    end else if (m_phase[k] == 0 && start) begin
      m_elapsed[k] = 0;
      if (m_val[k] > 0) m_phase[k] = 1;
      else begin
        m_phase[k] = 2;
        m_done[k] = 1;
      end
    end else if (m_phase[k] == 1 && !pause) begin
      m_elapsed[k]++;
      if (m_elapsed[k] == td) begin
        m_elapsed[k] = 0;
        m_val[k]--;
        if (m_val[k] == 0) begin
          m_phase[k] = 2;
          m_done[k] = 1;
        end
      end
    end
  endtask

  always @(posedge reset) model_reset();

  always @(posedge clk) begin
    if (reset) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
    #1;
    check("m_out4",  {24'b0, out4},  {24'b0, to_bcd(m_val[0])});
    check("m_run4",  {31'b0, run4},  {31'b0, m_phase[0] == 1});
    check("m_done4", {31'b0, done4}, {31'b0, m_done[0]});
    check("m_out1",  {24'b0, out1},  {24'b0, to_bcd(m_val[1])});
    check("m_run1",  {31'b0, run1},  {31'b0, m_phase[1] == 1});
    check("m_done1", {31'b0, done1}, {31'b0, m_done[1]});
  end

  task automatic edge_in(input logic ld, input logic [7:0] lv, input logic st, input logic ps);
    @(negedge clk);
    load = ld; load_val = lv; start = st; pause = ps;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out", {24'b0, out4}, 32'h0);
    check("rst_run", {31'b0, run4}, 32'h0);
    check("rst_done", {31'b0, done4}, 32'h0);
    reset = 1'b0;

    // TICK_DIV=1: 12 counts down every edge, 10 -> 09 borrow
    edge_in(1, 8'h12, 0, 0);
    edge_in(0, 8'h00, 1, 0);
    check("t1_start", {24'b0, out1}, 32'h12);
    for (int i = 11; i >= 0; i--) begin
      edge_in(0, 8'h00, 0, 0);
      check("t1_seq", {24'b0, out1}, {24'b0, to_bcd(i)});
      if (i == 9) check("t1_borrow", {24'b0, out1}, 32'h09);
    end
    check("t1_done", {31'b0, done1}, 32'h1);
    check("t1_runfall", {31'b0, run1}, 32'h0);
    edge_in(0, 8'h00, 0, 0);
    check("t1_done_clr", {31'b0, done1}, 32'h0);

    // TICK_DIV=4 latency
    edge_in(1, 8'h03, 0, 0);
    edge_in(0, 8'h00, 1, 0);
    for (int e = 1; e <= 12; e++) begin
      edge_in(0, 8'h00, 0, 0);
      if (e == 3)  check("t2_hold", {24'b0, out4}, 32'h03);
      if (e == 4)  check("t2_n4", {24'b0, out4}, 32'h02);
      if (e == 8)  check("t2_n8", {24'b0, out4}, 32'h01);
      if (e == 11) check("t2_nodone", {31'b0, done4}, 32'h0);
      if (e == 12) begin
        check("t2_n12", {24'b0, out4}, 32'h00);
        check("t2_done", {31'b0, done4}, 32'h1);
      end
    end

    // Pause for 5 cycles starting at N+6
    edge_in(1, 8'h03, 0, 0);
    edge_in(0, 8'h00, 1, 0);
    for (int e = 1; e <= 17; e++) begin
      edge_in(0, 8'h00, 0, (e >= 6 && e <= 10));
      if (e == 4)  check("t2p_n4", {24'b0, out4}, 32'h02);
      if (e == 8)  check("t2p_run", {31'b0, run4}, 32'h1);
      if (e == 12) check("t2p_n12", {24'b0, out4}, 32'h02);
      if (e == 13) check("t2p_n13", {24'b0, out4}, 32'h01);
      if (e == 16) check("t2p_n16", {24'b0, out4}, 32'h01);
      if (e == 17) begin
        check("t2p_n17", {24'b0, out4}, 32'h00);
        check("t2p_done", {31'b0, done4}, 32'h1);
      end
    end

    // Illegal nibble clamp and start on zero
    edge_in(1, 8'hA5, 0, 0);
    check("t3_a5", {24'b0, out4}, 32'h95);
    edge_in(1, 8'hFF, 0, 0);
    check("t3_ff", {24'b0, out4}, 32'h99);
    edge_in(1, 8'h00, 0, 0);
    edge_in(0, 8'h00, 1, 0);
    check("t3_zdone", {31'b0, done4}, 32'h1);
    check("t3_zrun", {31'b0, run4}, 32'h0);
    edge_in(0, 8'h00, 0, 0);
    check("t3_zdone_clr", {31'b0, done4}, 32'h0);
    check("t3_zout", {24'b0, out4}, 32'h00);

    // Load mid-run with simultaneous start
    edge_in(1, 8'h28, 0, 0);
    edge_in(0, 8'h00, 1, 0);
    repeat (4) edge_in(0, 8'h00, 0, 0);
    check("t4_27", {24'b0, out4}, 32'h27);
    edge_in(1, 8'h40, 1, 0);
    check("t4_load", {24'b0, out4}, 32'h40);
    check("t4_idle", {31'b0, run4}, 32'h0);
    check("t4_nodone", {31'b0, done4}, 32'h0);
    edge_in(0, 8'h00, 1, 0);
    check("t4_restart", {31'b0, run4}, 32'h1);
    repeat (4) edge_in(0, 8'h00, 0, 0);
    check("t4_39", {24'b0, out4}, 32'h39);

    // Async reset between edges
    edge_in(1, 8'h15, 0, 0);
    edge_in(0, 8'h00, 1, 0);
    edge_in(0, 8'h00, 0, 0);
    check("t5_pre", {24'b0, out4}, 32'h15);
    @(negedge clk);
    load = 0; start = 0; pause = 0;
    #1 reset = 1'b1;
    #1;
    check("t5_out", {24'b0, out4}, 32'h0);
    check("t5_run", {31'b0, run4}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < 6; e++) begin
      edge_in(0, 8'h00, 0, 0);
      check("t5_nodone", {31'b0, done4}, 32'h0);
    end

    // DONE ignores start and pause
    edge_in(1, 8'h01, 0, 0);
    edge_in(0, 8'h00, 1, 0);
    repeat (4) edge_in(0, 8'h00, 0, 0);
    check("t6_done", {31'b0, done4}, 32'h1);
    for (int e = 0; e < 4; e++) begin
      edge_in(0, 8'h00, 1, e[0]);
      check("t6_hold_out", {24'b0, out4}, 32'h00);
      check("t6_hold_done", {31'b0, done4}, 32'h0);
    end
    edge_in(1, 8'h01, 0, 0);
    edge_in(0, 8'h00, 1, 0);
    for (int e = 1; e <= 4; e++) begin
      edge_in(0, 8'h00, 0, 0);
      if (e == 3) check("t6_n3", {24'b0, out4}, 32'h01);
      if (e == 4) begin
        check("t6_n4", {24'b0, out4}, 32'h00);
        check("t6_n4_done", {31'b0, done4}, 32'h1);
      end
    end

    // Randomized traffic against the model
    for (int e = 0; e < 600; e++) begin
      edge_in(($urandom_range(0, 15) == 0), 8'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0));
    end
    edge_in(0, 8'h00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
